// File: rtl/bcd_pkg.sv
// Shared BCD constants for the cascaded up/down counter.
//   BCD_W   : width of one BCD digit
//   BCD_MAX : largest legal digit value (9)
//   BCD_MIN : smallest legal digit value (0)
package bcd_pkg;

  localparam int unsigned BCD_W = 4;

  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

  // True when a 4-bit field is not a legal BCD digit.
  function automatic logic bcd_invalid(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit cell of the up/down counter.
//   clk       : rising-edge clock
//   reset_n   : synchronous active-low reset (digit -> 0)
//   ld        : load ld_val (illegal values load as 0)
//   ld_val    : digit value to load
//   inc_en    : step this digit one place in direction dir
//   dir       : 1 = up, 0 = down
//   digit     : registered digit value, always 0..9
//   carry_out : digit sits at its terminal value for dir (9 up, 0 down)
module bcd_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ld,
  input  logic [BCD_W-1:0] ld_val,
  input  logic             inc_en,
  input  logic             dir,
  output logic [BCD_W-1:0] digit,
  output logic             carry_out
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      digit <= BCD_MIN;
    end else if (ld) begin
      digit <= bcd_invalid(ld_val) ? BCD_MIN : ld_val;
    end else if (inc_en) begin
      if (dir) begin
        digit <= (digit == BCD_MAX) ? BCD_MIN : digit + 4'd1;
      end else begin
        digit <= (digit == BCD_MIN) ? BCD_MAX : digit - 4'd1;
      end
    end
  end

  assign carry_out = dir ? (digit == BCD_MAX) : (digit == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter.sv
// Cascaded BCD up/down counter with synchronous load.
//   DIGITS     : number of BCD digits (1..8)
//   clk        : rising-edge clock
//   reset_n    : synchronous active-low reset
//   enable     : advance the count by one
//   up_down    : 1 = count up, 0 = count down
//   load       : load load_value (takes priority over enable)
//   load_value : packed BCD value, digit 0 in bits [3:0]
//   count      : registered packed BCD count
//   done       : all digits at terminal value for the current direction
//   wrap       : done & enable & ~load, for cascading further counters
//   load_err   : sticky flag, set by a load containing a digit > 9
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      up_down,
  input  logic                      load,
  input  logic [BCD_W*DIGITS-1:0]   load_value,
  output logic [BCD_W*DIGITS-1:0]   count,
  output logic                      done,
  output logic                      wrap,
  output logic                      load_err
);

  logic [BCD_W-1:0] digit_q [DIGITS];
  logic             carry   [DIGITS];
  // chain[i] = enable AND carry of every digit below i
  logic             chain   [DIGITS];
  logic             ld_bad;

  assign chain[0] = enable;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    if (i > 0) begin : g_chain
      assign chain[i] = chain[i-1] & carry[i-1];
    end

    bcd_digit u_digit (
      .clk       (clk),
      .reset_n   (reset_n),
      .ld        (load),
      .ld_val    (load_value[i*BCD_W +: BCD_W]),
      .inc_en    (chain[i]),
      .dir       (up_down),
      .digit     (digit_q[i]),
      .carry_out (carry[i])
    );
  end

  always_comb begin
    count = '0;
    done  = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      count[i*BCD_W +: BCD_W] = digit_q[i];
      done = done & carry[i];
    end
  end

  assign wrap = done & enable & ~load;

  always_comb begin
    ld_bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_invalid(load_value[i*BCD_W +: BCD_W])) ld_bad = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      load_err <= 1'b0;
    end else if (load) begin
      load_err <= ld_bad;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Self-checking bench for bcd_updown_counter (DIGITS=4): directed
// scenarios with literal expectations, then randomized traffic, all
// compared every cycle against an integer-valued reference model.
module tb_bcd_updown_counter;

  localparam int unsigned D   = 4;
  localparam int unsigned MOD = 10000;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            enable = 1'b0;
  logic            up_down = 1'b0;
  logic            load = 1'b0;
  logic [4*D-1:0]  load_value = '0;
  logic [4*D-1:0]  count;
  logic            done;
  logic            wrap;
  logic            load_err;

  bcd_updown_counter #(.DIGITS(D)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .up_down    (up_down),
    .load       (load),
    .load_value (load_value),
    .count      (count),
    .done       (done),
    .wrap       (wrap),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (plain integer arithmetic) ----------
  int unsigned m_cnt = 0;
  logic        m_err = 1'b0;
  logic        m_valid = 1'b0;

  function automatic int unsigned bcd_to_int(input logic [4*D-1:0] v);
    int unsigned r = 0;
    int unsigned w = 1;
    for (int i = 0; i < D; i++) begin
      int unsigned d = int'(v[i*4 +: 4]);
      if (d <= 9) r += d * w;
      w *= 10;
    end
    return r;
  endfunction

  function automatic logic has_bad(input logic [4*D-1:0] v);
    for (int i = 0; i < D; i++) begin
      if (int'(v[i*4 +: 4]) > 9) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [4*D-1:0] int_to_bcd(input int unsigned n);
    logic [4*D-1:0] r = '0;
    int unsigned v = n;
    for (int i = 0; i < D; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v /= 10;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_cnt   <= 0;
      m_err   <= 1'b0;
      m_valid <= 1'b1;
    end else if (load) begin
      m_cnt <= bcd_to_int(load_value);
      m_err <= has_bad(load_value);
    end else if (enable) begin
      m_cnt <= up_down ? (m_cnt + 1) % MOD : (m_cnt + MOD - 1) % MOD;
    end
  end

  // ---------------- literal expectations posted by the stimulus ---------
  logic           lit_cnt_v = 1'b0, lit_done_v = 1'b0, lit_wrap_v = 1'b0, lit_err_v = 1'b0;
  logic [4*D-1:0] lit_cnt = '0;
  logic           lit_done = 1'b0, lit_wrap = 1'b0, lit_err = 1'b0;

  // ---------------- compare process -------------------------------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      logic exp_done;
      exp_done = up_down ? (m_cnt == MOD - 1) : (m_cnt == 0);
      check("model_count", 32'(count), 32'(int_to_bcd(m_cnt)));
      check("model_done", 32'(done), 32'(exp_done));
      check("model_wrap", 32'(wrap), 32'(exp_done & enable & ~load));
      check("model_load_err", 32'(load_err), 32'(m_err));
    end
    if (lit_cnt_v)  check("lit_count", 32'(count), 32'(lit_cnt));
    if (lit_done_v) check("lit_done", 32'(done), 32'(lit_done));
    if (lit_wrap_v) check("lit_wrap", 32'(wrap), 32'(lit_wrap));
    if (lit_err_v)  check("lit_load_err", 32'(load_err), 32'(lit_err));
  end

  // ---------------- stimulus ---------------------------------------------
  // Drive inputs just after a rising edge, let the compare process sample
  // at the falling edge, then move on to the next rising edge.
  task automatic apply(input logic rst, input logic ld, input logic [4*D-1:0] lv,
                       input logic en, input logic ud);
    reset_n    = rst;
    load       = ld;
    load_value = lv;
    enable     = en;
    up_down    = ud;
    @(negedge clk);
    #1;
    lit_cnt_v  = 1'b0;
    lit_done_v = 1'b0;
    lit_wrap_v = 1'b0;
    lit_err_v  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cnt(input logic [4*D-1:0] c);
    lit_cnt_v = 1'b1;
    lit_cnt   = c;
  endtask

  task automatic expect_flags(input logic dn, input logic wr);
    lit_done_v = 1'b1; lit_done = dn;
    lit_wrap_v = 1'b1; lit_wrap = wr;
  endtask

  task automatic expect_err(input logic e);
    lit_err_v = 1'b1;
    lit_err   = e;
  endtask

  initial begin
    @(posedge clk);
    #1;
    // reset, then check zero state with down direction (done high)
    apply(1'b0, 1'b0, '0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, '0, 1'b0, 1'b0);
    expect_cnt(16'h0000); expect_flags(1'b1, 1'b0); expect_err(1'b0);
    apply(1'b1, 1'b0, '0, 1'b0, 1'b0);

    // 12 up steps
    for (int i = 0; i < 12; i++) apply(1'b1, 1'b0, '0, 1'b1, 1'b1);
    expect_cnt(16'h0012); expect_flags(1'b0, 1'b0);
    apply(1'b1, 1'b0, '0, 1'b0, 1'b1);

    // up wrap
    apply(1'b1, 1'b1, 16'h9998, 1'b0, 1'b1);
    expect_cnt(16'h9998);
    apply(1'b1, 1'b0, '0, 1'b1, 1'b1);
    expect_cnt(16'h9999); expect_flags(1'b1, 1'b1);
    apply(1'b1, 1'b0, '0, 1'b1, 1'b1);
    expect_cnt(16'h0000); expect_flags(1'b0, 1'b0);
    apply(1'b1, 1'b0, '0, 1'b0, 1'b1);

    // down borrow
    apply(1'b1, 1'b1, 16'h1000, 1'b0, 1'b0);
    apply(1'b1, 1'b0, '0, 1'b1, 1'b0);
    expect_cnt(16'h0999);
    apply(1'b1, 1'b0, '0, 1'b0, 1'b0);

    // down wrap
    apply(1'b1, 1'b1, 16'h0000, 1'b0, 1'b0);
    expect_cnt(16'h0000); expect_flags(1'b1, 1'b1);
    apply(1'b1, 1'b0, '0, 1'b1, 1'b0);
    expect_cnt(16'h9999); expect_flags(1'b0, 1'b0);
    apply(1'b1, 1'b0, '0, 1'b0, 1'b0);

    // invalid load, then a clean load clears the flag
    apply(1'b1, 1'b1, 16'h12A5, 1'b0, 1'b1);
    expect_cnt(16'h1205); expect_err(1'b1);
    apply(1'b1, 1'b0, '0, 1'b1, 1'b1);
    expect_err(1'b1);
    apply(1'b1, 1'b1, 16'h0042, 1'b0, 1'b1);
    expect_cnt(16'h0042); expect_err(1'b0);
    apply(1'b1, 1'b0, '0, 1'b0, 1'b1);

    // load beats enable; reset beats load
    apply(1'b1, 1'b1, 16'h0007, 1'b1, 1'b1);
    expect_cnt(16'h0007);
    apply(1'b0, 1'b1, 16'h1234, 1'b1, 1'b1);
    expect_cnt(16'h0000); expect_err(1'b0);
    apply(1'b1, 1'b0, '0, 1'b0, 1'b1);

    // direction toggling, then hold
    apply(1'b1, 1'b1, 16'h0050, 1'b0, 1'b1);
    for (int j = 0; j < 6; j++) begin
      if (j > 0) expect_cnt((j % 2 == 1) ? 16'h0051 : 16'h0050);
      apply(1'b1, 1'b0, '0, 1'b1, (j % 2 == 0));
    end
    for (int j = 0; j < 5; j++) begin
      expect_cnt(16'h0050);
      apply(1'b1, 1'b0, '0, 1'b0, j[0]);
    end

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      logic           r, l, e, u;
      logic [4*D-1:0] v;
      int unsigned    pick;
      r = ($urandom_range(0, 59) != 0);
      l = ($urandom_range(0, 7) == 0);
      e = ($urandom_range(0, 3) != 0);
      u = 1'($urandom_range(0, 1));
      pick = $urandom_range(0, 5);
      case (pick)
        0: v = 16'h9999;
        1: v = 16'h0000;
        2: v = 16'h9998;
        3: v = 16'h0001;
        default: v = 16'($urandom);
      endcase
      apply(r, l, v, e, u);
    end

    apply(1'b1, 1'b0, '0, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 4, giving the number of cascaded BCD digits (legal range 1..8).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, the reset; it is synchronous and active-low.
REQ-004 SHALL have port enable, input, 1, which advances the count by one when high.
REQ-005 SHALL have port up_down, input, 1, selecting direction: 1 counts up, 0 counts down.
REQ-006 SHALL have port load, input, 1, which loads load_value synchronously.
REQ-007 SHALL have port load_value, input, 4*DIGITS, a packed BCD value with digit 0 in bits [3:0].
REQ-008 SHALL have port count, output, 4*DIGITS, the registered packed BCD count.
REQ-009 SHALL have port done, output, 1, terminal count, combinational: all digits 9 when up_down=1, or all digits 0 when up_down=0.
REQ-010 SHALL have port wrap, output, 1, cascade carry/borrow, combinational: done & enable & ~load.
REQ-011 SHALL have port load_err, output, 1, registered sticky flag set when a loaded digit exceeds 9.

Function
REQ-012 SHALL apply priority reset_n low > load > enable > hold on every clock edge.
REQ-013 SHALL, on load, write each digit of load_value into count, replacing any digit greater than 9 with 0.
REQ-014 SHALL, on load, set load_err to 1 if any load_value digit exceeds 9, else clear it to 0.
REQ-015 SHALL hold load_err between loads, whatever enable does.
REQ-016 SHALL, counting up with enable, increment digit 0; a digit at 9 SHALL go to 0 and carry into the next digit.
REQ-017 SHALL, counting down with enable, decrement digit 0; a digit at 0 SHALL go to 9 and borrow from the next digit.
REQ-018 SHALL wrap the full count from 10^DIGITS-1 to 0 counting up, and from 0 to 10^DIGITS-1 counting down, in a single cycle.
REQ-019 SHALL keep count unchanged when enable=0 and load=0.
REQ-020 SHALL evaluate up_down changes in the same cycle they occur; the count has no direction pipeline.
REQ-021 SHALL give count a latency of one clock edge from enable or load.
REQ-022 SHALL never produce a count digit outside 0..9.
REQ-023 SHALL assert wrap for exactly one cycle per wrap event when enable stays high, so higher-order instances can be cascaded by tying their enable to wrap.

Reset
REQ-024 SHALL, while reset_n=0 at a rising clk edge, set count to all zeros and load_err to 0.
REQ-025 SHALL leave state unaffected by reset_n alone between clock edges, since reset is synchronous.
REQ-026 SHALL give reset precedence over a simultaneous load or enable.
REQ-027 SHALL, after reset with up_down=0, assert done immediately, because the count is all zeros.

Structure
REQ-028 SHALL place BCD_MAX (4'd9), BCD_MIN (4'd0) and the 4-bit digit width constant in shared package bcd_pkg.
REQ-029 SHALL instantiate DIGITS copies of sub-module bcd_digit, connected by a generate loop.
- bcd_digit ports: digit register, ld/ld_val, inc_en, dir, carry_out.
- carry_out is asserted at 9 when counting up and at 0 when counting down.
REQ-030 SHALL form digit i's inc_en as enable AND the carry_out of every lower digit.

Verification
REQ-031 SHALL cover reset and up-count, DIGITS=4:
- stimulus: reset, then enable=1, up_down=1 for 12 cycles.
- response: count=0x0012; done=0; wrap never asserted.
REQ-032 SHALL cover up wrap:
- stimulus: load 0x9998, then enable=1, up_down=1 for 2 cycles.
- response: count goes 0x9999 then 0x0000; done=1 and wrap=1 during the 0x9999 cycle.
REQ-033 SHALL cover down borrow and down wrap:
- stimulus: load 0x1000, then 1 down step.
- response: count=0x0999.
- stimulus: load 0x0000, then 1 down step.
- response: count=0x9999; wrap=1 in the cycle before.
REQ-034 SHALL cover invalid load:
- stimulus: load 0x12A5.
- response: count=0x1205; load_err=1.
- stimulus: then load 0x0042.
- response: load_err=0.
REQ-035 SHALL cover simultaneous events:
- stimulus: load=1 and enable=1 with load_value 0x0007.
- response: count=0x0007, not incremented.
- stimulus: reset_n=0 with load=1.
- response: count=0x0000.
REQ-036 SHALL cover direction change and hold:
- stimulus: at 0x0050, toggle up_down every cycle with enable=1.
- response: count alternates 0x0051 and 0x0050.
- stimulus: enable=0 for 5 cycles.
- response: count is stable.
